nbody_step_sequencer: RTL and testbench
=======================================

// Module: nbody_step_sequencer
// PURPOSE
// Parametrised control sequencer for the n-body accelerator: issues (i,j) pair addresses for the acceleration
// phase, tags velocity read/write-back and position update with latency-matched delay lines, counts STEPS,
// and runs the done/ack handshake. Adds hazard bubbles for small body counts, start rejection and go-abort.
// Sits between the bus register file and the position/velocity RAMs plus getAccl/AddSub datapath.
// PARAMETERS
// BODIES          512   max bodies held in RAM
// BODY_ADDR_WIDTH $clog2(BODIES)  body index width
// STEP_WIDTH      16    width of step count
// ACCL_LATENCY    103   cycles from pair-data-valid (RAM output) to acceleration valid
// ADD_LATENCY     20    AddSub pipeline depth
// ROW_MIN         ADD_LATENCY+2  minimum cycles between issues of the same j (RAW spacing)
// PORTS
// clk          in  1                 clock
// rst          in  1                 synchronous active-high reset
// go           in  1                 run enable; 0 aborts any run
// ack          in  1                 software read acknowledge
// num_bodies   in  BODY_ADDR_WIDTH+1 body count n (values > BODIES saturate to BODIES)
// steps        in  STEP_WIDTH        integration steps per run
// busy         out 1                 high in any non-IDLE/non-DONE state
// done         out 1                 run complete, held until ack
// half_kick    out 1                 first step since go rose: datapath halves acceleration
// step_count   out STEP_WIDTH        completed steps in current run
// pair_valid   out 1                 pair_i/pair_j valid this cycle
// pair_i,pair_j out BODY_ADDR_WIDTH  source/target body addresses
// vel_rd_valid out 1 / vel_rd_addr out BODY_ADDR_WIDTH  velocity RAM read
// vel_we       out 1 / vel_wr_addr out BODY_ADDR_WIDTH  velocity write-back
// pos_rd_valid out 1 / pos_rd_addr out BODY_ADDR_WIDTH  position+velocity read for update
// pos_we       out 1 / pos_wr_addr out BODY_ADDR_WIDTH  position write-back
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, delay lines cleared, half_kick armed (internal first flag=1).
// States IDLE, ACCEL, DRAIN_A, POS, DRAIN_P, DONE. n,steps latched on leaving IDLE.
// IDLE: go=0 rearms first flag. go=1 & ack=0: if n==0 or steps==0 -> DONE; else -> ACCEL, counters 0.
// ACCEL: j inner (0..n-1), i outer. Row lasts max(n,ROW_MIN) cycles; cycles past n are bubbles (pair_valid=0).
//  After issuing (n-1,n-1) -> DRAIN_A. No issue in the final row's bubbles.
// Pair issued cycle t: vel_rd_valid/addr=j at t+ACCL_LATENCY; vel_we/addr=j at t+ACCL_LATENCY+1+ADD_LATENCY.
// DRAIN_A: leave to POS cycle after last vel_we. POS: k=0..n-1, one per cycle on pos_rd_*;
//  pos_we/addr=k at t+1+ADD_LATENCY. After last issue -> DRAIN_P; cycle after last pos_we: step_count+1,
//  first flag cleared; if step_count+1==steps -> DONE else -> ACCEL.
// half_kick = first flag while in ACCEL/DRAIN_A.
// DONE: done=1. ack=1 -> done=0, -> IDLE; restart requires ack=0 again. go=0 in DONE -> IDLE, done=0.
// go=0 in ACCEL/DRAIN_A/POS/DRAIN_P: next cycle IDLE, all valid/we outputs and delay lines 0, done=0.
// Counters wrap-free: pair_j wraps n-1->0 with pair_i+1; step_count width STEP_WIDTH, steps=max not exceeded.
// rst mid-run: identical to reset, overrides go.
// TESTING
// n=3, steps=1, go=1: pairs (0,0),(0,1),(0,2)+19 bubbles per row, 3 rows; vel_we j=0 at T0+124; 9 vel_we, 3 pos_we, done.
// n=64, steps=3: 4096 pair_valid/step, no bubbles; step_count 0->1->2->3; half_kick only in step 0; done after 3rd pos.
// done=1, ack=1 -> done=0 next cycle; ack held 1 no restart; ack=0 -> new run with half_kick=0.
// go=0 mid-ACCEL (i=5) -> next cycle all valid/we=0, busy=0; go=1 -> restart at (0,0) with half_kick=1.
// n=0 or steps=0 -> done=1 within 2 cycles, zero we pulses; num_bodies=600 -> 512 bodies processed.
// rst asserted mid-POS -> next cycle every output 0, state IDLE, no further pos_we.

Source files
------------

// File: rtl/nbody_step_sequencer.sv
// Control sequencer for the n-body accelerator: pair issue, latency-matched
// velocity/position write-back tags, step counting and done/ack handshake.
module nbody_step_sequencer #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int STEP_WIDTH      = 16,
  parameter int ACCL_LATENCY    = 103,
  parameter int ADD_LATENCY     = 20,
  parameter int ROW_MIN         = ADD_LATENCY + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       ack,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  input  logic [STEP_WIDTH-1:0]      steps,
  output logic                       busy,
  output logic                       done,
  output logic                       half_kick,
  output logic [STEP_WIDTH-1:0]      step_count,
  output logic                       pair_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pair_i,
  output logic [BODY_ADDR_WIDTH-1:0] pair_j,
  output logic                       vel_rd_valid,
  output logic [BODY_ADDR_WIDTH-1:0] vel_rd_addr,
  output logic                       vel_we,
  output logic [BODY_ADDR_WIDTH-1:0] vel_wr_addr,
  output logic                       pos_rd_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr,
  output logic                       pos_we,
  output logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr
);

  localparam int BAW       = BODY_ADDR_WIDTH;
  localparam int NW        = BAW + 1;
  localparam int DRAIN_CYC = ACCL_LATENCY + ADD_LATENCY;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam int RW        = $clog2(ROW_MIN + 1);
  localparam int CW0       = (NW > DW) ? NW : DW;
  localparam int CW        = (CW0 > RW) ? CW0 : RW;
  localparam int VL        = ACCL_LATENCY + ADD_LATENCY + 1;
  localparam int PL        = ADD_LATENCY + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEL, S_DRAIN_A, S_POS, S_DRAIN_P, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic [STEP_WIDTH-1:0] step_count_q, step_count_d;
  logic                  first_q, first_d;
  logic [BAW-1:0]        i_q, i_d;
  logic [CW-1:0]         c_q, c_d;
  logic [BAW:0]          vel_dl_q [VL];
  logic [BAW:0]          vel_dl_d [VL];
  logic [BAW:0]          pos_dl_q [PL];
  logic [BAW:0]          pos_dl_d [PL];

  logic [NW-1:0]         n_sat;
  logic [CW-1:0]         n_c, row_len;
  logic                  last_col, last_row, row_end, abort;
  logic [STEP_WIDTH-1:0] step_inc;

  assign n_sat    = (num_bodies > NW'(BODIES)) ? NW'(BODIES) : num_bodies;
  assign n_c      = CW'(n_q);
  assign row_len  = (n_c > CW'(ROW_MIN)) ? n_c : CW'(ROW_MIN);
  assign last_col = (c_q == n_c - CW'(1));
  assign last_row = (CW'(i_q) == n_c - CW'(1));
  assign row_end  = (c_q == row_len - CW'(1));
  assign step_inc = step_count_q + STEP_WIDTH'(1);
  assign abort    = busy && !go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      steps_q      <= '0;
      step_count_q <= '0;
      first_q      <= 1'b1;
      i_q          <= '0;
      c_q          <= '0;
      vel_dl_q     <= '{default: '0};
      pos_dl_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      steps_q      <= steps_d;
      step_count_q <= step_count_d;
      first_q      <= first_d;
      i_q          <= i_d;
      c_q          <= c_d;
      vel_dl_q     <= vel_dl_d;
      pos_dl_q     <= pos_dl_d;
    end
  end

  // c_q is shared: column in ACCEL, body in POS, drain timer in DRAIN_A/DRAIN_P.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    steps_d      = steps_q;
    step_count_d = step_count_q;
    first_d      = first_q;
    i_d          = i_q;
    c_d          = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (!go) begin
          first_d = 1'b1;
        end else if (!ack) begin
          n_d          = n_sat;
          steps_d      = steps;
          step_count_d = '0;
          i_d          = '0;
          c_d          = '0;
          state_d      = (n_sat == '0 || steps == '0) ? S_DONE : S_ACCEL;
        end
      end
      S_ACCEL: begin
        if (last_row && last_col) begin
          state_d = S_DRAIN_A;
          c_d     = '0;
        end else if (row_end) begin
          c_d = '0;
          i_d = i_q + BAW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DRAIN_A: begin
        if (c_q == CW'(DRAIN_CYC)) begin
          state_d = S_POS;
          c_d     = '0;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_POS: begin
        if (last_col) begin
          state_d = S_DRAIN_P;
          c_d     = '0;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DRAIN_P: begin
        if (c_q == CW'(ADD_LATENCY)) begin
          step_count_d = step_inc;
          first_d      = 1'b0;
          i_d          = '0;
          c_d          = '0;
          state_d      = (step_inc == steps_q) ? S_DONE : S_ACCEL;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DONE: begin
        if (ack || !go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = (state_q == S_DONE);
    half_kick    = first_q && (state_q == S_ACCEL || state_q == S_DRAIN_A);
    step_count   = step_count_q;
    pair_valid   = (state_q == S_ACCEL) && (c_q < n_c);
    pair_i       = pair_valid ? i_q : '0;
    pair_j       = pair_valid ? c_q[BAW-1:0] : '0;
    pos_rd_valid = (state_q == S_POS);
    pos_rd_addr  = pos_rd_valid ? c_q[BAW-1:0] : '0;
  end

  // Tag delay lines carry {valid, addr}; an abort flushes every in-flight tag.
  always_comb begin
    vel_dl_d[0] = {pair_valid, pair_j};
    for (int unsigned k = 1; k < VL; k++) vel_dl_d[k] = vel_dl_q[k-1];
    pos_dl_d[0] = {pos_rd_valid, pos_rd_addr};
    for (int unsigned k = 1; k < PL; k++) pos_dl_d[k] = pos_dl_q[k-1];
    if (abort) begin
      vel_dl_d = '{default: '0};
      pos_dl_d = '{default: '0};
    end
  end

  assign vel_rd_valid = vel_dl_q[ACCL_LATENCY-1][BAW];
  assign vel_rd_addr  = vel_dl_q[ACCL_LATENCY-1][BAW-1:0];
  assign vel_we       = vel_dl_q[VL-1][BAW];
  assign vel_wr_addr  = vel_dl_q[VL-1][BAW-1:0];
  assign pos_we       = pos_dl_q[PL-1][BAW];
  assign pos_wr_addr  = pos_dl_q[PL-1][BAW-1:0];

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Testbench for nbody_step_sequencer: event streams are compared with a
// timing model derived from the pair/row/drain rules.
module tb_nbody_step_sequencer;
  localparam int BAW = 9, SW = 16, ACCL = 103, ADD = 20, ROWMIN = 22;

  logic clk = 1'b0, rst, go, ack;
  logic [BAW:0] num_bodies;
  logic [SW-1:0] steps, step_count;
  logic busy, done, half_kick, pair_valid, vel_rd_valid, vel_we, pos_rd_valid, pos_we;
  logic [BAW-1:0] pair_i, pair_j, vel_rd_addr, vel_wr_addr, pos_rd_addr, pos_wr_addr;

  nbody_step_sequencer #(.BODIES(512), .STEP_WIDTH(SW), .ACCL_LATENCY(ACCL), .ADD_LATENCY(ADD)) dut (
    .clk(clk), .rst(rst), .go(go), .ack(ack), .num_bodies(num_bodies), .steps(steps),
    .busy(busy), .done(done), .half_kick(half_kick), .step_count(step_count),
    .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
    .vel_rd_valid(vel_rd_valid), .vel_rd_addr(vel_rd_addr), .vel_we(vel_we), .vel_wr_addr(vel_wr_addr),
    .pos_rd_valid(pos_rd_valid), .pos_rd_addr(pos_rd_addr), .pos_we(pos_we), .pos_wr_addr(pos_wr_addr));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0] cyc; logic [2:0] typ; logic [9:0] a; logic [9:0] b; logic hk; logic [15:0] sc;
  } ev_t;
  ev_t obs_q[$], exp_q[$];
  int checks = 0, failures = 0;

  logic [77:0] outs_vec;
  assign outs_vec = {busy, done, half_kick, step_count, pair_valid, pair_i, pair_j, vel_rd_valid,
                     vel_rd_addr, vel_we, vel_wr_addr, pos_rd_valid, pos_rd_addr, pos_we, pos_wr_addr};

  function automatic ev_t mk_ev(int unsigned c, int t, int unsigned a, int unsigned b, bit hk, int unsigned sc);
    ev_t e;
    e.cyc = 24'(c); e.typ = 3'(t); e.a = 10'(a); e.b = 10'(b); e.hk = hk; e.sc = 16'(sc);
    return e;
  endfunction

  // typ: 0 pair, 1 vel read, 2 vel write, 3 pos read, 4 pos write
  always @(negedge clk) begin
    if (pair_valid)   obs_q.push_back(mk_ev(cyc, 0, pair_i, pair_j, half_kick, step_count));
    if (vel_rd_valid) obs_q.push_back(mk_ev(cyc, 1, vel_rd_addr, 0, 0, 0));
    if (vel_we)       obs_q.push_back(mk_ev(cyc, 2, vel_wr_addr, 0, 0, 0));
    if (pos_rd_valid) obs_q.push_back(mk_ev(cyc, 3, pos_rd_addr, 0, 0, 0));
    if (pos_we)       obs_q.push_back(mk_ev(cyc, 4, pos_wr_addr, 0, 0, 0));
  end

  // Expected schedule: pair (i,j) of a step at start+i*row+j, row=max(n,ROWMIN).
  task automatic build_model(input int n, input int st, input int unsigned t0, input bit hk,
                             output int unsigned d);
    int r;
    int unsigned ts, t, tl, p0;
    r = (n > ROWMIN) ? n : ROWMIN;
    ts = t0;
    exp_q.delete();
    for (int s = 0; s < st; s++) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          t = ts + i * r + j;
          exp_q.push_back(mk_ev(t, 0, i, j, hk && (s == 0), s));
          exp_q.push_back(mk_ev(t + ACCL, 1, j, 0, 0, 0));
          exp_q.push_back(mk_ev(t + ACCL + ADD + 1, 2, j, 0, 0, 0));
        end
      tl = ts + (n - 1) * r + (n - 1);
      p0 = tl + ACCL + ADD + 2;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mk_ev(p0 + k, 3, k, 0, 0, 0));
        exp_q.push_back(mk_ev(p0 + k + ADD + 1, 4, k, 0, 0, 0));
      end
      ts = p0 + (n - 1) + ADD + 2;
    end
    d = ts;
    exp_q.sort();
  endtask

  task automatic start_run(input int n, input int st, output int unsigned t0);
    @(negedge clk);
    go = 1'b0; ack = 1'b0; num_bodies = (BAW+1)'(n); steps = SW'(st);
    repeat (3) @(negedge clk);
    obs_q.delete();
    go = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; ack = 1'b0; num_bodies = '0; steps = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_vec !== '0) begin failures++; $display("FAIL reset_outs: got %h want 0", outs_vec); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_vec !== '0) begin failures++; $display("FAIL idle_outs: got %h want 0", outs_vec); end
  endtask

  task automatic test_small;
    int unsigned t0, d; int bad = -1, nvw = 0, npw = 0, vw0 = -1;
    start_run(3, 1, t0);
    build_model(3, 1, t0, 1'b1, d);
    while (!done && cyc < d + 20) @(negedge clk);
    checks++;
    if (!(done && cyc == d)) begin failures++; $display("FAIL small_done: done=%b at %0d want 1 at %0d", done, cyc, d); end
    foreach (obs_q[k]) begin
      if (obs_q[k].typ == 3'd2) begin nvw++; if (vw0 < 0) vw0 = int'(obs_q[k].cyc); end
      if (obs_q[k].typ == 3'd4) npw++;
    end
    checks++;
    if (nvw != 9 || npw != 3 || vw0 != int'(t0 + 124)) begin
      failures++; $display("FAIL small_we: vel_we=%0d pos_we=%0d first_vel_we=%0d want 9 3 %0d", nvw, npw, vw0, t0 + 124);
    end
    foreach (exp_q[k]) if (bad < 0 && (k >= obs_q.size() || obs_q[k] !== exp_q[k])) bad = k;
    checks++;
    if (bad >= 0 || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL small_stream: idx %0d got %h want %h (events %0d want %0d)", bad,
               (bad >= 0 && bad < obs_q.size()) ? obs_q[bad] : ev_t'(0), (bad >= 0) ? exp_q[bad] : ev_t'(0), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_ack;
    int unsigned t0, d; int bad = -1; bit moved = 0;
    ack = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ack_clear: done=%b busy=%b want 0 0", done, busy); end
    repeat (5) begin @(negedge clk); if (busy || done) moved = 1; end
    checks++;
    if (moved) begin failures++; $display("FAIL ack_hold: restarted=%b want 0", moved); end
    obs_q.delete();
    ack = 1'b0;
    t0 = cyc + 1;
    build_model(3, 1, t0, 1'b0, d);
    while (!done && cyc < d + 20) @(negedge clk);
    checks++;
    if (!(done && cyc == d)) begin failures++; $display("FAIL ack_rerun_done: done=%b at %0d want 1 at %0d", done, cyc, d); end
    foreach (exp_q[k]) if (bad < 0 && (k >= obs_q.size() || obs_q[k] !== exp_q[k])) bad = k;
    checks++;
    if (bad >= 0 || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ack_rerun_stream: idx %0d got %h want %h (events %0d want %0d)", bad,
               (bad >= 0 && bad < obs_q.size()) ? obs_q[bad] : ev_t'(0), (bad >= 0) ? exp_q[bad] : ev_t'(0), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_large;
    int unsigned t0, d; int bad = -1;
    start_run(64, 3, t0);
    build_model(64, 3, t0, 1'b1, d);
    while (!done && cyc < d + 20) @(negedge clk);
    checks++;
    if (!(done && cyc == d && step_count == 16'd3)) begin
      failures++; $display("FAIL large_done: done=%b at %0d steps=%0d want 1 at %0d steps=3", done, cyc, step_count, d);
    end
    foreach (exp_q[k]) if (bad < 0 && (k >= obs_q.size() || obs_q[k] !== exp_q[k])) bad = k;
    checks++;
    if (bad >= 0 || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL large_stream: idx %0d got %h want %h (events %0d want %0d)", bad,
               (bad >= 0 && bad < obs_q.size()) ? obs_q[bad] : ev_t'(0), (bad >= 0) ? exp_q[bad] : ev_t'(0), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random;
    int unsigned t0, d; int n, st, bad;
    repeat (4) begin
      n = int'($urandom_range(1, 40)); st = int'($urandom_range(1, 3)); bad = -1;
      start_run(n, st, t0);
      build_model(n, st, t0, 1'b1, d);
      while (!done && cyc < d + 20) @(negedge clk);
      checks++;
      if (!(done && cyc == d && step_count == SW'(st))) begin
        failures++; $display("FAIL rand_done n=%0d s=%0d: done=%b at %0d steps=%0d want at %0d", n, st, done, cyc, step_count, d);
      end
      foreach (exp_q[k]) if (bad < 0 && (k >= obs_q.size() || obs_q[k] !== exp_q[k])) bad = k;
      checks++;
      if (bad >= 0 || obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand_stream n=%0d s=%0d: idx %0d got %h want %h (events %0d want %0d)", n, st, bad,
                 (bad >= 0 && bad < obs_q.size()) ? obs_q[bad] : ev_t'(0), (bad >= 0) ? exp_q[bad] : ev_t'(0), obs_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_abort;
    int unsigned t0, d; int n, bad = -1; bit found = 0;
    n = int'($urandom_range(8, 30));
    start_run(n, 2, t0);
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk);
      if (pair_valid && pair_i == 9'd5) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL abort_reach_i5: reached=%b want 1", found); end
    go = 1'b0;
    @(negedge clk);
    checks++;
    if ({pair_valid, vel_rd_valid, vel_we, pos_rd_valid, pos_we, busy, done} !== 7'b0) begin
      failures++; $display("FAIL abort_outs: got %b want 0", {pair_valid, vel_rd_valid, vel_we, pos_rd_valid, pos_we, busy, done});
    end
    obs_q.delete();
    repeat (200) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL abort_quiet: events=%0d want 0", obs_q.size()); end
    go = 1'b1;
    t0 = cyc + 1;
    build_model(n, 2, t0, 1'b1, d);
    while (!done && cyc < d + 20) @(negedge clk);
    checks++;
    if (!(done && cyc == d)) begin failures++; $display("FAIL abort_restart_done: done=%b at %0d want 1 at %0d", done, cyc, d); end
    foreach (exp_q[k]) if (bad < 0 && (k >= obs_q.size() || obs_q[k] !== exp_q[k])) bad = k;
    checks++;
    if (bad >= 0 || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL abort_restart_stream: idx %0d got %h want %h (events %0d want %0d)", bad,
               (bad >= 0 && bad < obs_q.size()) ? obs_q[bad] : ev_t'(0), (bad >= 0) ? exp_q[bad] : ev_t'(0), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_zero;
    int unsigned t0; bit seen;
    for (int c = 0; c < 2; c++) begin
      seen = 0;
      start_run((c == 0) ? 0 : 7, (c == 0) ? 4 : 0, t0);
      repeat (2) begin @(negedge clk); if (done) seen = 1; end
      checks++;
      if (!seen) begin failures++; $display("FAIL zero_done case %0d: done seen=%b want 1", c, seen); end
      repeat (10) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || done !== 1'b1) begin
        failures++; $display("FAIL zero_quiet case %0d: events=%0d done=%b want 0 1", c, obs_q.size(), done);
      end
    end
  endtask

  task automatic test_saturate;
    int unsigned t0; int bad = -1, ei, ej;
    start_run(600, 1, t0);
    for (int c = 0; c < 514; c++) begin
      @(negedge clk);
      ei = c / 512; ej = c % 512;
      if (bad < 0 && (!pair_valid || pair_i != 9'(ei) || pair_j != 9'(ej) || cyc != t0 + c)) bad = c;
    end
    checks++;
    if (bad >= 0) begin
      failures++; $display("FAIL saturate_pairs: at offset %0d got valid=%b (%0d,%0d) want (%0d,%0d)", bad,
                           pair_valid, pair_i, pair_j, bad / 512, bad % 512);
    end
    go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rst_mid_pos;
    int unsigned t0; int n; bit found = 0;
    n = int'($urandom_range(4, 20));
    start_run(n, 2, t0);
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (pos_rd_valid && pos_rd_addr == 9'd2) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rst_reach_pos: reached=%b want 1", found); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_vec !== '0) begin failures++; $display("FAIL rst_mid_outs: got %h want 0", outs_vec); end
    @(negedge clk);
    checks++;
    if (outs_vec !== '0) begin failures++; $display("FAIL rst_over_go: got %h want 0", outs_vec); end
    rst = 1'b0; go = 1'b0;
    obs_q.delete();
    repeat (40) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rst_no_pos_we: events=%0d want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_small();
    test_ack();
    test_large();
    test_random();
    test_abort();
    test_zero();
    test_saturate();
    test_rst_mid_pos();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
